inst_cache: RTL and testbench

Direct-mapped instruction cache between the fetch stage and `InstructionMemory`. It accepts a 32-bit byte PC and returns the 32-bit instruction. On a miss it drives the line address to `InstructionMemory` (`InsAddress`), waits a fixed latency, and captures the 128-bit `dataline` into a line. It hides memory latency on hits and turns the 4-word line interface into a single-word fetch interface.

---
 rtl/inst_cache_pkg.sv | 22 ++
 rtl/inst_cache_tagram.sv | 46 ++++
 rtl/inst_cache.sv | 137 +++++++++++++
 tb/tb_inst_cache.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package inst_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS_WAIT,
    FILL
  } state_t;

  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = 4;
  localparam int WSEL_W         = $clog2(WORDS_PER_LINE);

  // Word k of a line occupies bits [32k+31:32k].
  function automatic logic [31:0] select_word(input logic [LINE_W-1:0] line,
                                              input logic [WSEL_W-1:0] k);
    return line[{k, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/inst_cache_tagram.sv
// Valid/tag/data storage for the instruction cache: one async read port,
// one write port, and a synchronous clear of all valid bits.
module inst_cache_tagram
  import inst_cache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int IW    = 3,
  parameter int TAG_W = 25
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [IW-1:0]     rd_index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // Clearing takes precedence so a reset during a fill leaves the line invalid.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache between fetch and InstructionMemory.
// Optional hit/miss counters are enabled with `define INST_CACHE_STATS_EN.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int LINES       = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              fetch_req,
  input  logic [31:0]       PC,
  input  logic              flush,
  output logic [31:0]       instruction,
  output logic              ins_valid,
  output logic              busy,
  output logic [31:0]       mem_addr,
  input  logic [LINE_W-1:0] mem_line
`ifdef INST_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IW    = $clog2(LINES);
  localparam int TAG_W = 32 - OFFSET_W - IW;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:2]       pc_q;
  logic [31:0]       instr_q, word_out;
  logic              fill_en, hit, clear_all;
  logic [IW-1:0]     idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] woff;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^PC[1:0];

  assign idx       = pc_q[OFFSET_W +: IW];
  assign tag       = pc_q[31 -: TAG_W];
  assign woff      = pc_q[3:2];
  assign hit       = rd_valid && (rd_tag == tag);
  assign clear_all = RST || (state_q == IDLE && flush);
  assign busy      = (state_q != IDLE);
  assign mem_addr  = (state_q == IDLE) ? {4'b0, PC[31:4]} : {4'b0, pc_q[31:4]};
  assign instruction = word_out;

  inst_cache_tagram #(
    .LINES(LINES),
    .IW   (IW),
    .TAG_W(TAG_W)
  ) u_tagram (
    .clk     (CLK),
    .clear   (clear_all),
    .rd_index(idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (fill_en),
    .wr_index(idx),
    .wr_tag  (tag),
    .wr_data (mem_line)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ins_valid = 1'b0;
    fill_en   = 1'b0;
    word_out  = instr_q;
    case (state_q)
      IDLE: begin
        if (fetch_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          ins_valid = 1'b1;
          word_out  = select_word(rd_data, woff);
          state_d   = IDLE;
        end else begin
          cnt_d   = CNT_W'(MEM_LATENCY);
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = FILL;
      end
      FILL: begin
        fill_en   = 1'b1;
        ins_valid = 1'b1;
        word_out  = select_word(mem_line, woff);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset in the final cycle of a miss must neither respond nor fill.
    if (RST) begin
      ins_valid = 1'b0;
      fill_en   = 1'b0;
      word_out  = instr_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ins_valid) instr_q <= word_out;
      if (state_q == IDLE && fetch_req) pc_q <= PC[31:2];
    end
  end

`ifdef INST_CACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level cache model.
module tb_inst_cache;

  localparam int LINES       = 8;
  localparam int MEM_LATENCY = 2;
  localparam int IW          = $clog2(LINES);

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         fetch_req = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  PC = '0;
  logic [31:0]  instruction, mem_addr;
  logic         ins_valid, busy;
  logic [127:0] mem_line;
`ifdef INST_CACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  int errors  = 0;
  int checks  = 0;
  bit started = 1'b0;

  always #5 CLK = ~CLK;

  inst_cache #(
    .LINES      (LINES),
    .MEM_LATENCY(MEM_LATENCY)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .fetch_req  (fetch_req),
    .PC         (PC),
    .flush      (flush),
    .instruction(instruction),
    .ins_valid  (ins_valid),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_line   (mem_line)
`ifdef INST_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Instruction memory: line L word k = A000_0000 | L<<4 | k, MEM_LATENCY cycles late.
  logic [31:0] addrPipe [MEM_LATENCY] = '{default: '0};

  initial forever begin
    @(posedge CLK);
    addrPipe[0] <= mem_addr;
    for (int i = 1; i < MEM_LATENCY; i++) addrPipe[i] <= addrPipe[i-1];
  end

  always_comb begin
    mem_line = '0;
    for (int k = 0; k < 4; k++)
      mem_line[32*k +: 32] = 32'hA000_0000 | (addrPipe[MEM_LATENCY-1] << 4) | 32'(k);
  end

  // Transaction-level model: lookup at acceptance, response after a fixed delay.
  bit          mValid [LINES];
  int unsigned mTag   [LINES];
  bit          mBusy = 1'b0, mHit = 1'b0, mStatPending = 1'b0;
  int          mRemain = 0;
  logic [31:0] mPc = '0, mInstr = '0;
  int unsigned mHits = 0, mMisses = 0;

  function automatic logic [31:0] expWord(input logic [31:0] pc);
    return 32'hA000_0000 | ((pc >> 4) << 4) | ((pc >> 2) & 32'd3);
  endfunction

  function automatic int lineIdx(input logic [31:0] pc);
    return int'((pc >> 4) % LINES);
  endfunction

  initial forever begin
    @(posedge CLK);
    if (RST) begin
      foreach (mValid[i]) mValid[i] = 1'b0;
      mBusy = 1'b0; mStatPending = 1'b0; mRemain = 0;
      mInstr = '0; mHits = 0; mMisses = 0;
    end else if (!mBusy) begin
      if (flush) foreach (mValid[i]) mValid[i] = 1'b0;
      if (fetch_req) begin
        mPc          = PC;
        mHit         = mValid[lineIdx(PC)] && (mTag[lineIdx(PC)] == (PC >> (4 + IW)));
        mBusy        = 1'b1;
        mStatPending = 1'b1;
        mRemain      = mHit ? 1 : 2 + MEM_LATENCY;
      end
    end else begin
      if (mStatPending) begin
        if (mHit) mHits++; else mMisses++;
        mStatPending = 1'b0;
      end
      if (mRemain == 1) begin
        if (!mHit) begin
          mValid[lineIdx(mPc)] = 1'b1;
          mTag[lineIdx(mPc)]   = mPc >> (4 + IW);
        end
        mInstr = expWord(mPc);
        mBusy  = 1'b0;
      end
      mRemain--;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCycle();
    logic expValid;
    expValid = mBusy && (mRemain == 1);
    checkOutput("ins_valid", 32'(ins_valid), 32'(expValid));
    checkOutput("busy", 32'(busy), 32'(mBusy));
    checkOutput("mem_addr", mem_addr, mBusy ? (mPc >> 4) : (PC >> 4));
    checkOutput("instruction", instruction, expValid ? expWord(mPc) : mInstr);
`ifdef INST_CACHE_STATS_EN
    checkOutput("hit_count", hit_count, mHits);
    checkOutput("miss_count", miss_count, mMisses);
`endif
  endtask

  initial forever begin
    @(negedge CLK);
    if (started && !RST) checkCycle();
  end

  task automatic doReset();
    @(posedge CLK); #1;
    RST = 1'b1; fetch_req = 1'b0; flush = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  // One fetch: returns cycles from acceptance to ins_valid (0 on timeout).
  task automatic applyStimulus(input logic [31:0] pc, input logic withFlush,
                               output int lat, output logic [31:0] ins,
                               output logic [31:0] addrSeen);
    @(posedge CLK); #1;
    PC = pc; fetch_req = 1'b1; flush = withFlush;
    @(posedge CLK); #1;
    fetch_req = 1'b0; flush = 1'b0;
    lat = 0; ins = '0; addrSeen = mem_addr;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (ins_valid) begin
        lat = i;
        ins = instruction;
        break;
      end
    end
  endtask

  initial begin
    int          lat, pulses;
    logic [31:0] ins, addr;

    doReset();
    started = 1'b1;
    @(negedge CLK);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ins_valid", 32'(ins_valid), 32'd0);
    checkOutput("reset instruction", instruction, 32'd0);

    applyStimulus(32'h18, 1'b0, lat, ins, addr);
    checkOutput("cold miss mem_addr", addr, 32'd1);
    checkOutput("cold miss latency", lat, 32'd4);
    checkOutput("cold miss data", ins, 32'hA000_0012);

    applyStimulus(32'h1C, 1'b0, lat, ins, addr);
    checkOutput("hit latency", lat, 32'd1);
    checkOutput("hit data", ins, 32'hA000_0013);
    checkOutput("hit mem_addr", addr, 32'd1);

    doReset();
    applyStimulus(32'h10, 1'b0, lat, ins, addr);
    checkOutput("conflict first latency", lat, 32'd4);
    checkOutput("conflict first data", ins, 32'hA000_0010);
    applyStimulus(32'h90, 1'b0, lat, ins, addr);
    checkOutput("conflict second latency", lat, 32'd4);
    checkOutput("conflict second data", ins, 32'hA000_0090);
    checkOutput("conflict second mem_addr", addr, 32'd9);
    applyStimulus(32'h10, 1'b0, lat, ins, addr);
    checkOutput("conflict third latency", lat, 32'd4);
`ifdef INST_CACHE_STATS_EN
    checkOutput("conflict hit_count", hit_count, 32'd0);
    checkOutput("conflict miss_count", miss_count, 32'd3);
`endif

    applyStimulus(32'h18, 1'b0, lat, ins, addr);
    checkOutput("cached hit latency", lat, 32'd1);
    checkOutput("cached hit data", ins, 32'hA000_0012);
    applyStimulus(32'h18, 1'b1, lat, ins, addr);
    checkOutput("flush+req latency", lat, 32'd4);
    checkOutput("flush+req data", ins, 32'hA000_0012);

    // Reset while waiting on memory.
    @(posedge CLK); #1;
    PC = 32'h28; fetch_req = 1'b1;
    @(posedge CLK); #1;
    fetch_req = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    pulses = 0;
    @(negedge CLK);
    if (ins_valid) pulses++;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("busy after reset", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (ins_valid) pulses++;
      @(negedge CLK);
    end
    checkOutput("pulses after reset", pulses, 32'd0);
    applyStimulus(32'h28, 1'b0, lat, ins, addr);
    checkOutput("refetch after reset latency", lat, 32'd4);
    checkOutput("refetch after reset data", ins, 32'hA000_0022);

    // Request pulsed with another PC while a miss is outstanding.
    @(posedge CLK); #1;
    PC = 32'h38; fetch_req = 1'b1;
    @(posedge CLK); #1;
    fetch_req = 1'b0;
    pulses = 0; ins = '0;
    @(negedge CLK);
    if (ins_valid) begin pulses++; ins = instruction; end
    @(posedge CLK); #1;
    PC = 32'h48; fetch_req = 1'b1;
    @(negedge CLK);
    if (ins_valid) begin pulses++; ins = instruction; end
    @(posedge CLK); #1;
    PC = 32'h38; fetch_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (ins_valid) begin pulses++; ins = instruction; end
    end
    checkOutput("busy request pulses", pulses, 32'd1);
    checkOutput("busy request data", ins, 32'hA000_0032);

    // Randomized traffic; PC only changes while the cache is idle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK); #1;
      RST = ($urandom_range(0, 99) == 0);
      if (!mBusy) PC = ($urandom_range(0, 31) << 4) | $urandom_range(0, 15);
      fetch_req = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
    end
    @(posedge CLK); #1;
    RST = 1'b0; fetch_req = 1'b0; flush = 1'b0;
    repeat (10) @(posedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
